// File: rtl/free_list_arbiter_pkg.sv
// Shared definitions for the free-list arbiter: tag-width derivation,
// allocation FSM encoding, physical tag type and the round-robin pick.
package free_list_arbiter_pkg;

    // Upper bound on requesters the round-robin pick can scan.
    localparam int MAX_REQ   = 16;
    localparam int MAX_REQ_W = 4;

    // Tag width for a register file of n entries (at least one bit).
    function automatic int unsigned log_phys(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NUM_PHYS_REGS_DEF = 64;
    localparam int LOG_PHYS_DEF      = log_phys(NUM_PHYS_REGS_DEF);

    // Physical register tag at the default register-file size.
    typedef logic [LOG_PHYS_DEF-1:0] phys_tag_t;

    // Allocation FSM: IDLE issues a dequeue, WAIT consumes its result.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } alloc_state_t;

    // First set request at or after ptr, wrapping modulo n. Returns 0 when
    // nothing is set; callers only use the result when some bit is set.
    function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] req,
                                            input int unsigned        ptr,
                                            input int unsigned        n);
        int unsigned idx;
        logic        found;
        rr_pick = 0;
        found   = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = ptr + i;
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((i < n) && !found && (idx < MAX_REQ) && req[idx[MAX_REQ_W-1:0]]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/free_list_arbiter_release.sv
// Release buffer: circular FIFO accepting up to two tags per cycle (port a
// is written before port b) and draining one tag per cycle whenever it is
// non-empty. Both pushes are refused unless two slots are free.
module release_fifo
    import free_list_arbiter_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_a,
    input  logic [DATA_W-1:0] data_a,
    input  logic              push_b,
    input  logic [DATA_W-1:0] data_b,
    output logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic              do_a;
    logic              do_b;
    logic [PTR_W-1:0]  tail_b;
    logic [CNT_W-1:0]  push_cnt;

    // Readiness, drain and write-slot selection from the registered pointers.
    always_comb begin
        ready    = (CNT_W'(DEPTH) - count) >= CNT_W'(2);
        pop      = (count != '0);
        pop_data = pop ? mem[head] : '0;
        do_a     = push_a & ready;
        do_b     = push_b & ready;
        tail_b   = do_a ? (tail + PTR_W'(1)) : tail;
        push_cnt = CNT_W'(do_a) + CNT_W'(do_b);
    end

    // Tag storage; the retire slot precedes the squash slot when both push.
    always_ff @(posedge clk) begin
        if (do_a) begin
            mem[tail] <= data_a;
        end
        if (do_b) begin
            mem[tail_b] <= data_b;
        end
    end

    // Pointers and occupancy; push and drain may land in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop);
            tail  <= tail + PTR_W'(push_cnt);
            count <= count + push_cnt - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/free_list_arbiter.sv
// Free-list arbiter: round-robin allocation of physical tags to rename
// lanes through a registered-result dequeue port, plus a release buffer
// that funnels retire/squash frees into the free-list enqueue port.
module free_list_arbiter
    import free_list_arbiter_pkg::*;
#(
    parameter  int NUM_PHYS_REGS = 64,
    parameter  int NUM_REQ       = 2,
    parameter  int REL_DEPTH     = 4,
    localparam int LOG_PHYS      = log_phys(NUM_PHYS_REGS),
    localparam int RR_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [NUM_REQ-1:0]  Alloc_Req_IN,
    output logic [NUM_REQ-1:0]  Alloc_Grant_OUT,
    output logic                Alloc_Valid_OUT,
    output logic [LOG_PHYS-1:0] Alloc_Reg_OUT,
    output logic                Alloc_Empty_OUT,
    input  logic                Retire_Valid_IN,
    input  logic [LOG_PHYS-1:0] Retire_Reg_IN,
    input  logic                Squash_Valid_IN,
    input  logic [LOG_PHYS-1:0] Squash_Reg_IN,
    output logic                Release_Ready_OUT,
    output logic                FL_Dequeue_OUT,
    input  logic                FL_DequeueResult_IN,
    input  logic [LOG_PHYS-1:0] FL_Data_IN,
    output logic                FL_Enqueue_OUT,
    output logic [LOG_PHYS-1:0] FL_Data_OUT
);

    alloc_state_t       state;
    alloc_state_t       state_next;
    logic [RR_W-1:0]    winner;
    logic [RR_W-1:0]    winner_next;
    logic [RR_W-1:0]    rr_ptr;
    logic [RR_W-1:0]    rr_ptr_next;
    logic               empty;
    logic               empty_next;
    logic               deq;
    logic               fire;
    logic [MAX_REQ-1:0] req_ext;

    logic                fifo_pop;
    logic [LOG_PHYS-1:0] fifo_data;
    logic                fifo_ready;

    release_fifo #(
        .DEPTH  (REL_DEPTH),
        .DATA_W (LOG_PHYS)
    ) u_release_fifo (
        .clk      (CLK),
        .rst      (RESET),
        .push_a   (Retire_Valid_IN),
        .data_a   (Retire_Reg_IN),
        .push_b   (Squash_Valid_IN),
        .data_b   (Squash_Reg_IN),
        .pop      (fifo_pop),
        .pop_data (fifo_data),
        .ready    (fifo_ready)
    );

    // Allocation FSM next state: dequeue and pick a winner in IDLE, deliver
    // or record an empty free list in WAIT. While empty, wait for an enqueue.
    always_comb begin
        state_next  = state;
        winner_next = winner;
        rr_ptr_next = rr_ptr;
        empty_next  = empty;
        deq         = 1'b0;
        fire        = 1'b0;
        req_ext     = MAX_REQ'(Alloc_Req_IN);
        case (state)
            IDLE: begin
                if (empty && fifo_pop) begin
                    empty_next = 1'b0;
                end
                if ((|Alloc_Req_IN) && !empty) begin
                    deq         = 1'b1;
                    winner_next = RR_W'(rr_pick(req_ext, 32'(rr_ptr), NUM_REQ));
                    state_next  = WAIT;
                end
            end
            WAIT: begin
                state_next = IDLE;
                if (FL_DequeueResult_IN) begin
                    fire        = 1'b1;
                    rr_ptr_next = (winner == RR_W'(NUM_REQ - 1)) ? '0 : winner + RR_W'(1);
                    empty_next  = 1'b0;
                end else begin
                    empty_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM, fairness pointer and empty flag; reset also discards a pending result.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= IDLE;
            rr_ptr <= '0;
            empty  <= 1'b0;
        end else begin
            state  <= state_next;
            rr_ptr <= rr_ptr_next;
            empty  <= empty_next;
        end
    end

    // Winner lane latched at dequeue time so later request changes cannot redirect it.
    always_ff @(posedge CLK) begin
        winner <= winner_next;
    end

    // Output drive; reset holds everything quiet except release readiness.
    always_comb begin
        Alloc_Valid_OUT   = fire & ~RESET;
        Alloc_Grant_OUT   = '0;
        Alloc_Reg_OUT     = '0;
        if (Alloc_Valid_OUT) begin
            Alloc_Grant_OUT = NUM_REQ'(1) << winner;
            Alloc_Reg_OUT   = FL_Data_IN;
        end
        Alloc_Empty_OUT   = empty & ~RESET;
        FL_Dequeue_OUT    = deq & ~RESET;
        FL_Enqueue_OUT    = fifo_pop & ~RESET;
        FL_Data_OUT       = RESET ? '0 : fifo_data;
        Release_Ready_OUT = fifo_ready | RESET;
    end

endmodule

// File: tb/tb_free_list_arbiter.sv
// Testbench for free_list_arbiter: directed scenarios plus a randomized run
// checked against a queue-based reference model of the arbiter and buffer.
module tb_free_list_arbiter;

    localparam int NREQ  = 2;
    localparam int DEPTH = 4;
    localparam int LW    = 6;

    logic            CLK = 1'b0;
    logic            RESET;
    logic [NREQ-1:0] Alloc_Req_IN;
    logic [NREQ-1:0] Alloc_Grant_OUT;
    logic            Alloc_Valid_OUT;
    logic [LW-1:0]   Alloc_Reg_OUT;
    logic            Alloc_Empty_OUT;
    logic            Retire_Valid_IN;
    logic [LW-1:0]   Retire_Reg_IN;
    logic            Squash_Valid_IN;
    logic [LW-1:0]   Squash_Reg_IN;
    logic            Release_Ready_OUT;
    logic            FL_Dequeue_OUT;
    logic            FL_DequeueResult_IN;
    logic [LW-1:0]   FL_Data_IN;
    logic            FL_Enqueue_OUT;
    logic [LW-1:0]   FL_Data_OUT;

    int errors = 0;
    int checks = 0;

    free_list_arbiter #(
        .NUM_PHYS_REGS (64),
        .NUM_REQ       (NREQ),
        .REL_DEPTH     (DEPTH)
    ) dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .Alloc_Req_IN        (Alloc_Req_IN),
        .Alloc_Grant_OUT     (Alloc_Grant_OUT),
        .Alloc_Valid_OUT     (Alloc_Valid_OUT),
        .Alloc_Reg_OUT       (Alloc_Reg_OUT),
        .Alloc_Empty_OUT     (Alloc_Empty_OUT),
        .Retire_Valid_IN     (Retire_Valid_IN),
        .Retire_Reg_IN       (Retire_Reg_IN),
        .Squash_Valid_IN     (Squash_Valid_IN),
        .Squash_Reg_IN       (Squash_Reg_IN),
        .Release_Ready_OUT   (Release_Ready_OUT),
        .FL_Dequeue_OUT      (FL_Dequeue_OUT),
        .FL_DequeueResult_IN (FL_DequeueResult_IN),
        .FL_Data_IN          (FL_Data_IN),
        .FL_Enqueue_OUT      (FL_Enqueue_OUT),
        .FL_Data_OUT         (FL_Data_OUT)
    );

    always #5 CLK = ~CLK;

    // Observed outputs packed as {deq, valid, grant, reg, empty, enq, fl_data, ready}.
    function automatic logic [18:0] obs();
        return {FL_Dequeue_OUT, Alloc_Valid_OUT, Alloc_Grant_OUT, Alloc_Reg_OUT,
                Alloc_Empty_OUT, FL_Enqueue_OUT, FL_Data_OUT, Release_Ready_OUT};
    endfunction

    function automatic logic [18:0] pack(input logic deq, input logic val,
                                         input logic [1:0] gr, input logic [5:0] rg,
                                         input logic emp, input logic enq,
                                         input logic [5:0] fd, input logic rdy);
        return {deq, val, gr, rg, emp, enq, fd, rdy};
    endfunction

    task automatic clear_inputs();
        Alloc_Req_IN        = '0;
        Retire_Valid_IN     = 1'b0;
        Retire_Reg_IN       = '0;
        Squash_Valid_IN     = 1'b0;
        Squash_Reg_IN       = '0;
        FL_DequeueResult_IN = 1'b0;
        FL_Data_IN          = '0;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        clear_inputs();
        RESET = 1'b1;
        next_cycle();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        logic [18:0] e;
        e = pack(0, 0, 2'b00, 0, 0, 0, 0, 1);
        RESET = 1'b1;
        Alloc_Req_IN = 2'b11;
        Retire_Valid_IN = 1'b1; Retire_Reg_IN = 6'd5;
        Squash_Valid_IN = 1'b1; Squash_Reg_IN = 6'd8;
        FL_DequeueResult_IN = 1'b1; FL_Data_IN = 6'd7;
        #2;
        checks++; if (obs() !== e) begin errors++; $display("FAIL reset_t0: got %h expected %h", obs(), e); end
        next_cycle();
        checks++; if (obs() !== e) begin errors++; $display("FAIL reset_c1: got %h expected %h", obs(), e); end
        next_cycle();
        checks++; if (obs() !== e) begin errors++; $display("FAIL reset_c2: got %h expected %h", obs(), e); end
        RESET = 1'b0;
        clear_inputs();
        #1;
        checks++; if (obs() !== e) begin errors++; $display("FAIL reset_release: got %h expected %h", obs(), e); end
    endtask

    task automatic test_alloc_rr();
        logic [18:0] e;
        do_reset();
        Alloc_Req_IN = 2'b11;
        #1; e = pack(1, 0, 2'b00, 0, 0, 0, 0, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL rr_deq0: got %h expected %h", obs(), e); end
        next_cycle(); FL_DequeueResult_IN = 1'b1; FL_Data_IN = 6'd5;
        #1; e = pack(0, 1, 2'b01, 6'd5, 0, 0, 0, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL rr_grant_lane0: got %h expected %h", obs(), e); end
        next_cycle(); FL_DequeueResult_IN = 1'b0; FL_Data_IN = 6'd0;
        #1; e = pack(1, 0, 2'b00, 0, 0, 0, 0, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL rr_deq1: got %h expected %h", obs(), e); end
        next_cycle(); FL_DequeueResult_IN = 1'b1; FL_Data_IN = 6'd6;
        #1; e = pack(0, 1, 2'b10, 6'd6, 0, 0, 0, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL rr_grant_lane1: got %h expected %h", obs(), e); end
        next_cycle(); Alloc_Req_IN = 2'b00; FL_DequeueResult_IN = 1'b0; FL_Data_IN = 6'd0;
        #1; e = pack(0, 0, 2'b00, 0, 0, 0, 0, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL rr_idle: got %h expected %h", obs(), e); end
    endtask

    task automatic test_deassert_in_wait();
        logic [18:0] e;
        do_reset();
        Alloc_Req_IN = 2'b10;
        #1; e = pack(1, 0, 2'b00, 0, 0, 0, 0, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL dw_deq: got %h expected %h", obs(), e); end
        next_cycle(); Alloc_Req_IN = 2'b00; FL_DequeueResult_IN = 1'b1; FL_Data_IN = 6'd33;
        #1; e = pack(0, 1, 2'b10, 6'd33, 0, 0, 0, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL dw_grant_latched: got %h expected %h", obs(), e); end
        next_cycle(); Alloc_Req_IN = 2'b11; FL_DequeueResult_IN = 1'b0; FL_Data_IN = 6'd0;
        #1; e = pack(1, 0, 2'b00, 0, 0, 0, 0, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL dw_deq2: got %h expected %h", obs(), e); end
        next_cycle(); FL_DequeueResult_IN = 1'b1; FL_Data_IN = 6'd34;
        #1; e = pack(0, 1, 2'b01, 6'd34, 0, 0, 0, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL dw_ptr_wrap: got %h expected %h", obs(), e); end
    endtask

    task automatic test_empty();
        logic [18:0] e;
        do_reset();
        Alloc_Req_IN = 2'b01;
        #1; e = pack(1, 0, 2'b00, 0, 0, 0, 0, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL em_deq: got %h expected %h", obs(), e); end
        next_cycle(); FL_DequeueResult_IN = 1'b0;
        #1; e = pack(0, 0, 2'b00, 0, 0, 0, 0, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL em_no_grant: got %h expected %h", obs(), e); end
        next_cycle();
        #1; e = pack(0, 0, 2'b00, 0, 1, 0, 0, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL em_flag_set: got %h expected %h", obs(), e); end
        next_cycle();
        #1;
        checks++; if (obs() !== e) begin errors++; $display("FAIL em_blocked: got %h expected %h", obs(), e); end
        next_cycle(); Retire_Valid_IN = 1'b1; Retire_Reg_IN = 6'd9;
        #1;
        checks++; if (obs() !== e) begin errors++; $display("FAIL em_push9: got %h expected %h", obs(), e); end
        next_cycle(); Retire_Valid_IN = 1'b0; Retire_Reg_IN = 6'd0;
        #1; e = pack(0, 0, 2'b00, 0, 1, 1, 6'd9, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL em_drain9: got %h expected %h", obs(), e); end
        next_cycle();
        #1; e = pack(1, 0, 2'b00, 0, 0, 0, 0, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL em_reissue: got %h expected %h", obs(), e); end
        next_cycle(); FL_DequeueResult_IN = 1'b1; FL_Data_IN = 6'd9;
        #1; e = pack(0, 1, 2'b01, 6'd9, 0, 0, 0, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL em_grant9: got %h expected %h", obs(), e); end
    endtask

    task automatic test_release_pair();
        logic [18:0] e;
        do_reset();
        Retire_Valid_IN = 1'b1; Retire_Reg_IN = 6'd3;
        Squash_Valid_IN = 1'b1; Squash_Reg_IN = 6'd7;
        #1; e = pack(0, 0, 2'b00, 0, 0, 0, 0, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL rp_push: got %h expected %h", obs(), e); end
        next_cycle(); Retire_Valid_IN = 1'b0; Squash_Valid_IN = 1'b0;
        #1; e = pack(0, 0, 2'b00, 0, 0, 1, 6'd3, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL rp_first3: got %h expected %h", obs(), e); end
        next_cycle();
        #1; e = pack(0, 0, 2'b00, 0, 0, 1, 6'd7, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL rp_second7: got %h expected %h", obs(), e); end
        next_cycle();
        #1; e = pack(0, 0, 2'b00, 0, 0, 0, 0, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL rp_empty: got %h expected %h", obs(), e); end
    endtask

    task automatic test_fill_wrap();
        logic [18:0] e;
        logic [5:0]  base;
        do_reset();
        Retire_Valid_IN = 1'b1; Retire_Reg_IN = 6'd50;
        #1; e = pack(0, 0, 2'b00, 0, 0, 0, 0, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL fw_offset_push: got %h expected %h", obs(), e); end
        next_cycle(); Retire_Valid_IN = 1'b0;
        #1; e = pack(0, 0, 2'b00, 0, 0, 1, 6'd50, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL fw_offset_drain: got %h expected %h", obs(), e); end
        for (int r = 0; r < 3; r++) begin
            base = 6'(10 + r * 8);
            next_cycle();
            Retire_Valid_IN = 1'b1; Retire_Reg_IN = base;
            Squash_Valid_IN = 1'b1; Squash_Reg_IN = base + 6'd1;
            #1; e = pack(0, 0, 2'b00, 0, 0, 0, 0, 1);
            checks++; if (obs() !== e) begin errors++; $display("FAIL fw_r%0d_c1: got %h expected %h", r, obs(), e); end
            next_cycle();
            Retire_Reg_IN = base + 6'd2; Squash_Reg_IN = base + 6'd3;
            #1; e = pack(0, 0, 2'b00, 0, 0, 1, base, 1);
            checks++; if (obs() !== e) begin errors++; $display("FAIL fw_r%0d_c2: got %h expected %h", r, obs(), e); end
            next_cycle();
            Retire_Reg_IN = 6'd60; Squash_Reg_IN = 6'd61;
            #1; e = pack(0, 0, 2'b00, 0, 0, 1, base + 6'd1, 0);
            checks++; if (obs() !== e) begin errors++; $display("FAIL fw_r%0d_not_ready: got %h expected %h", r, obs(), e); end
            next_cycle();
            Retire_Valid_IN = 1'b0; Squash_Valid_IN = 1'b0;
            #1; e = pack(0, 0, 2'b00, 0, 0, 1, base + 6'd2, 1);
            checks++; if (obs() !== e) begin errors++; $display("FAIL fw_r%0d_c4: got %h expected %h", r, obs(), e); end
            next_cycle();
            #1; e = pack(0, 0, 2'b00, 0, 0, 1, base + 6'd3, 1);
            checks++; if (obs() !== e) begin errors++; $display("FAIL fw_r%0d_c5: got %h expected %h", r, obs(), e); end
            next_cycle();
            #1; e = pack(0, 0, 2'b00, 0, 0, 0, 0, 1);
            checks++; if (obs() !== e) begin errors++; $display("FAIL fw_r%0d_drained: got %h expected %h", r, obs(), e); end
        end
    endtask

    task automatic test_reset_in_wait();
        logic [18:0] e;
        do_reset();
        Alloc_Req_IN = 2'b01;
        #1; e = pack(1, 0, 2'b00, 0, 0, 0, 0, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL rw_deq: got %h expected %h", obs(), e); end
        next_cycle(); RESET = 1'b1; FL_DequeueResult_IN = 1'b1; FL_Data_IN = 6'd11;
        #1; e = pack(0, 0, 2'b00, 0, 0, 0, 0, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL rw_no_grant: got %h expected %h", obs(), e); end
        next_cycle(); RESET = 1'b0; Alloc_Req_IN = 2'b00; FL_DequeueResult_IN = 1'b1;
        #1;
        checks++; if (obs() !== e) begin errors++; $display("FAIL rw_after: got %h expected %h", obs(), e); end
        next_cycle(); Alloc_Req_IN = 2'b11; FL_DequeueResult_IN = 1'b0; FL_Data_IN = 6'd0;
        #1; e = pack(1, 0, 2'b00, 0, 0, 0, 0, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL rw_redeq: got %h expected %h", obs(), e); end
        next_cycle(); FL_DequeueResult_IN = 1'b1; FL_Data_IN = 6'd12;
        #1; e = pack(0, 1, 2'b01, 6'd12, 0, 0, 0, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL rw_rr_reset: got %h expected %h", obs(), e); end
    endtask

    // Random traffic against a model: a pending flag with a latched lane, a
    // fairness pointer, an empty flag and a plain queue for the release buffer.
    task automatic test_random();
        bit          m_pend;
        int          m_win;
        int          m_rr;
        bit          m_empty;
        int          q[$];
        bit          rst, x_val, x_deq, x_emp, x_enq, x_rdy;
        logic [1:0]  x_gr;
        logic [5:0]  x_reg, x_fd;
        logic [18:0] e;
        do_reset();
        m_pend = 0; m_win = 0; m_rr = 0; m_empty = 0; q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst                 = ($urandom_range(0, 63) == 0);
            RESET               = rst;
            Alloc_Req_IN        = 2'($urandom_range(0, 3));
            Retire_Valid_IN     = ($urandom_range(0, 1) == 1);
            Retire_Reg_IN       = 6'($urandom_range(0, 63));
            Squash_Valid_IN     = ($urandom_range(0, 9) < 3);
            Squash_Reg_IN       = 6'($urandom_range(0, 63));
            FL_DequeueResult_IN = ($urandom_range(0, 1) == 1);
            FL_Data_IN          = 6'($urandom_range(0, 63));
            #1;
            x_val = !rst && m_pend && FL_DequeueResult_IN;
            x_gr  = x_val ? 2'(1 << m_win) : 2'b00;
            x_reg = x_val ? FL_Data_IN : 6'd0;
            x_deq = !rst && !m_pend && (Alloc_Req_IN != 0) && !m_empty;
            x_emp = !rst && m_empty;
            x_enq = !rst && (q.size() > 0);
            x_fd  = x_enq ? 6'(q[0]) : 6'd0;
            x_rdy = rst || ((DEPTH - q.size()) >= 2);
            e = pack(x_deq, x_val, x_gr, x_reg, x_emp, x_enq, x_fd, x_rdy);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h expected %h", cyc, obs(), e);
            end
            if (rst) begin
                m_pend = 0; m_rr = 0; m_empty = 0; q.delete();
            end else begin
                if (m_pend) begin
                    m_pend = 0;
                    if (FL_DequeueResult_IN) begin
                        m_rr = (m_win + 1) % NREQ;
                        m_empty = 0;
                    end else begin
                        m_empty = 1;
                    end
                end else begin
                    if (m_empty && x_enq) m_empty = 0;
                    if (x_deq) begin
                        bit got;
                        got = 0;
                        m_pend = 1;
                        for (int k = 0; k < NREQ; k++) begin
                            if (!got && Alloc_Req_IN[(m_rr + k) % NREQ]) begin
                                m_win = (m_rr + k) % NREQ;
                                got = 1;
                            end
                        end
                    end
                end
                if (x_enq) void'(q.pop_front());
                if (x_rdy) begin
                    if (Retire_Valid_IN) q.push_back(int'(Retire_Reg_IN));
                    if (Squash_Valid_IN) q.push_back(int'(Squash_Reg_IN));
                end
            end
            next_cycle();
        end
        RESET = 1'b0;
    endtask

    initial begin
        clear_inputs();
        RESET = 1'b1;
        test_reset();
        test_alloc_rr();
        test_deassert_in_wait();
        test_empty();
        test_release_pair();
        test_fill_wrap();
        test_reset_in_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/free_list_arbiter.md
FREE_LIST_ARBITER -- requirements
Module: free_list_arbiter

Interface
REQ-001 Parameter NUM_PHYS_REGS, default 64: physical register count; tag width LOG_PHYS = clog2(NUM_PHYS_REGS).
REQ-002 Parameter NUM_REQ, default 2: number of allocation requesters (rename lanes).
REQ-003 Parameter REL_DEPTH, default 4: release buffer depth, power of two, at least 2.
REQ-004 CLK  in  1  sole clock, all state updates on posedge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 Alloc_Req_IN  in  NUM_REQ  per-lane request, held high until granted.
REQ-007 Alloc_Grant_OUT  out  NUM_REQ  one-hot grant, valid only with Alloc_Valid_OUT.
REQ-008 Alloc_Valid_OUT  out  1  one-cycle pulse: Alloc_Reg_OUT is delivered to the granted lane.
REQ-009 Alloc_Reg_OUT  out  LOG_PHYS  allocated physical tag.
REQ-010 Alloc_Empty_OUT  out  1  sticky: last dequeue failed.
REQ-011 Retire_Valid_IN / Retire_Reg_IN  in  1 / LOG_PHYS  tag freed at commit.
REQ-012 Squash_Valid_IN / Squash_Reg_IN  in  1 / LOG_PHYS  tag freed by mispredict squash.
REQ-013 Release_Ready_OUT  out  1  buffer can accept two pushes this cycle.
REQ-014 FL_Dequeue_OUT  out  1;  FL_DequeueResult_IN  in  1;  FL_Data_IN  in  LOG_PHYS: free-list dequeue port, result registered one cycle after the request.
REQ-015 FL_Enqueue_OUT  out  1;  FL_Data_OUT  out  LOG_PHYS: free-list enqueue port.

Function
REQ-016 Allocation FSM states: IDLE and WAIT.
REQ-017 IDLE, any Alloc_Req_IN set: assert FL_Dequeue_OUT combinationally; latch winner = first set bit at or after rr_ptr (wrapping); go to WAIT.
REQ-018 IDLE, no request: FL_Dequeue_OUT=0; stay in IDLE.
REQ-019 WAIT with FL_DequeueResult_IN=1: Alloc_Valid_OUT=1, Alloc_Reg_OUT=FL_Data_IN, Alloc_Grant_OUT=onehot(winner), rr_ptr <= (winner+1) mod NUM_REQ, clear Alloc_Empty_OUT, go to IDLE.
REQ-020 WAIT with FL_DequeueResult_IN=0: no grant; set Alloc_Empty_OUT; rr_ptr unchanged; go to IDLE.
REQ-021 Alloc_Empty_OUT set: no new dequeue issued until FL_Enqueue_OUT has been asserted; the flag clears on the cycle after that enqueue.
REQ-022 Peak allocation throughput: one grant per two cycles; grant latency from request to Alloc_Valid_OUT is 1 cycle (request in IDLE, grant in WAIT).
REQ-023 Requests deasserted while in WAIT: the grant is still issued to the latched winner.
REQ-024 Release buffer: circular FIFO of REL_DEPTH tags; count width clog2(REL_DEPTH)+1.
REQ-025 Release_Ready_OUT = (REL_DEPTH - count) >= 2, computed from registered count.
REQ-026 Pushes accepted only when Release_Ready_OUT=1; a push while not ready is dropped.
REQ-027 Retire and squash push in the same cycle: retire tag written first, squash tag second; count increments by 2.
REQ-028 Drain: count>0 gives FL_Enqueue_OUT=1 and FL_Data_OUT=head entry; head advances the same cycle; one tag per cycle.
REQ-029 Push and drain in the same cycle: both occur; count = count + pushes - 1.
REQ-030 Head and tail pointers wrap modulo REL_DEPTH.
REQ-031 Allocation and release paths are independent; both free-list ports may be active in the same cycle.

Reset
REQ-032 RESET high at posedge: FSM to IDLE, rr_ptr=0, FIFO head/tail/count=0, Alloc_Empty_OUT=0.
REQ-033 While RESET is high, all outputs are 0, except Release_Ready_OUT, which is 1.
REQ-034 RESET asserted during WAIT: the pending dequeue result is discarded and no grant is issued.

Structure
REQ-035 A shared package holds LOG_PHYS derivation, the FSM state encoding (IDLE, WAIT) and the phys-tag type.
REQ-036 The release buffer is a sub-module, release_fifo (2-push, 1-pop).
REQ-037 The round-robin pick is a function in the package; no separate module.

Verification
REQ-038 Alloc_Req_IN=2'b11 held; free list returns 5, then 6 -> lane 0 gets 5, lane 1 gets 6, grants two cycles apart.
REQ-039 Alloc_Req_IN=2'b01; FL_DequeueResult_IN=0 -> no Alloc_Valid_OUT, Alloc_Empty_OUT=1, FL_Dequeue_OUT stays 0 until a release of tag 9 drains, then a dequeue is reissued.
REQ-040 Retire 3 and Squash 7 in the same cycle, FIFO empty -> FL_Data_OUT=3, then 7, on consecutive cycles.
REQ-041 Four pushes without a drain opportunity -> Release_Ready_OUT drops at count 3; tail wrap verified over 3 fill/drain rounds.
REQ-042 RESET pulsed in WAIT -> no grant; next cycle all outputs 0 except Release_Ready_OUT=1.
